// File: rtl/fetch_stall_pkg.sv
// Shared constants for the fetch stage: default widths, PC increment and the
// instruction encoding written into IF/ID on a flush.
package fetch_stall_pkg;

  localparam int unsigned DefN     = 64;
  localparam int unsigned DefIw    = 32;
  localparam int unsigned DefPcInc = 4;

  localparam logic [DefIw-1:0] NopInstr = '0;

endpackage

// File: rtl/fetch_stall_if.sv
// Fetch-stage bundle: hazard/redirect controls and imem data in, IF/ID state out.
// The slave side is the fetch stage itself; master is whoever drives it.
interface fetch_stall_if #(
  parameter int unsigned N  = 64,
  parameter int unsigned IW = 32
);

  logic          PCSrc_F;
  logic [N-1:0]  PCBranch_F;
  logic          Stall_F;
  logic [IW-1:0] instr_F;
  logic [N-1:0]  imem_addr_F;
  logic [N-1:0]  PC_D;
  logic [IW-1:0] instr_D;
  logic          valid_D;

  modport master (
    output PCSrc_F, PCBranch_F, Stall_F, instr_F,
    input  imem_addr_F, PC_D, instr_D, valid_D
  );

  modport slave (
    input  PCSrc_F, PCBranch_F, Stall_F, instr_F,
    output imem_addr_F, PC_D, instr_D, valid_D
  );

endinterface

// File: rtl/flopr_en.sv
// Enable-gated register with synchronous reset and synchronous clear.
// Priority: reset > clear > enable.
module flopr_en #(
  parameter int unsigned  W       = 1,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RST_VAL;
    end else if (clr) begin
      q <= CLR_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stall.sv
// Instruction-fetch stage: PC register with redirect/stall control feeding a
// single IF/ID pipeline register that is flushed on redirect.
module fetch_stall
  import fetch_stall_pkg::*;
#(
  parameter int unsigned  N        = DefN,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter int unsigned  PC_INC   = DefPcInc,
  parameter int unsigned  IW       = DefIw
) (
  input logic          clk,
  input logic          reset,
  fetch_stall_if.slave bus
);

  localparam int unsigned IfIdW = N + IW + 1;
  // Flushed IF/ID content: PC_D=0, instr_D=NOP, valid_D=0.
  localparam logic [IfIdW-1:0] IfIdFlush = {{N{1'b0}}, IW'(NopInstr), 1'b0};

  logic [N-1:0]     pc_q;
  logic [N-1:0]     pc_plus;
  logic [N-1:0]     pc_next;
  logic             pc_en;
  logic [IfIdW-1:0] ifid_d;
  logic [IfIdW-1:0] ifid_q;

  // Redirect wins over stall; the adder wraps modulo 2^N silently.
  assign pc_plus = pc_q + N'(PC_INC);
  assign pc_next = bus.PCSrc_F ? bus.PCBranch_F : pc_plus;
  assign pc_en   = bus.PCSrc_F | ~bus.Stall_F;

  flopr_en #(
    .W       (N),
    .RST_VAL (RESET_PC),
    .CLR_VAL ('0)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .en    (pc_en),
    .clr   (1'b0),
    .d     (pc_next),
    .q     (pc_q)
  );

  assign ifid_d = {pc_q, bus.instr_F, 1'b1};

  // Clear takes precedence over the stall-gated enable, so stall+redirect flushes.
  flopr_en #(
    .W       (IfIdW),
    .RST_VAL ('0),
    .CLR_VAL (IfIdFlush)
  ) u_ifid_reg (
    .clk   (clk),
    .reset (reset),
    .en    (~bus.Stall_F),
    .clr   (bus.PCSrc_F),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign bus.imem_addr_F = pc_q;
  assign bus.PC_D        = ifid_q[IfIdW-1 -: N];
  assign bus.instr_D     = ifid_q[IW:1];
  assign bus.valid_D     = ifid_q[0];

endmodule
